// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and redirect priority encoding for the prefetching fetch stage
package fetch_pkg;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP         = 32'h0000_0013;

   typedef enum logic [1:0] {
      REDIR_NONE     = 2'd0,
      REDIR_BRANCH   = 2'd1,
      REDIR_PC_WRITE = 2'd2
   } redir_src_e;

   // The memory-stage redirect belongs to the older instruction, so it outranks decode.
   function automatic redir_src_e redir_select(input logic pc_write, input logic branch);
      if (pc_write) begin
         return REDIR_PC_WRITE;
      end
      if (branch) begin
         return REDIR_BRANCH;
      end
      return REDIR_NONE;
   endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// rtl/fetch_prefetch_if.sv - instruction-memory request/response bus between fetch and memory
interface fetch_prefetch_if #(
   parameter int XLEN = 32
) ();

   logic            im_req;
   logic            im_ready;
   logic [XLEN-1:0] im_addr;
   logic            im_valid;
   logic [XLEN-1:0] im_data;

   modport master (
      output im_req,
      output im_addr,
      input  im_ready,
      input  im_valid,
      input  im_data
   );

   modport slave (
      input  im_req,
      input  im_addr,
      output im_ready,
      output im_valid,
      output im_data
   );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// rtl/fetch_prefetch_fifo.sv - first-word fall-through FIFO holding {pc, instr} pairs; flush beats push
module sync_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(do_push && full_o));
      end
   end

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - prefetching fetch stage: in-order imem reads ahead of decode,
// buffered in a FIFO, with redirect flush and discard of wrong-path responses still in flight.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter int              MAX_INFLIGHT = 2,
   parameter logic [XLEN-1:0] RESET_PC     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_prefetch_if.master      im,
   input  logic                  branch_d_i,
   input  logic [XLEN-1:0]       branch_next_addr_d_i,
   input  logic                  pc_write_m_i,
   input  logic [XLEN-1:0]       pc_next_addr_m_i,
   input  logic                  stall_f_i,
   output logic                  valid_f_o,
   output logic [XLEN-1:0]       instruction_f_o,
   output logic [XLEN-1:0]       pc_f_o
);

   localparam int              CW   = $clog2(DEPTH + 1);
   localparam int              IW   = $clog2(MAX_INFLIGHT + 1);
   localparam int              SW   = ((CW > IW) ? CW : IW) + 1;
   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
   logic [IW-1:0]     inflight_q, inflight_d;
   logic [IW-1:0]     discard_q, discard_d;

   redir_src_e        redir_src;
   logic              redir;
   logic [XLEN-1:0]   target_raw, target;

   logic              accept, resp, push, pop;
   logic [IW-1:0]     pending;
   logic [SW-1:0]     credit_used;

   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [2*XLEN-1:0] fifo_head;

   assign redir_src = redir_select(pc_write_m_i, branch_d_i);
   assign redir     = (redir_src != REDIR_NONE);

   always_comb begin
      target_raw = fetch_pc_q;
      case (redir_src)
         REDIR_PC_WRITE: target_raw = pc_next_addr_m_i;
         REDIR_BRANCH:   target_raw = branch_next_addr_d_i;
         default:        target_raw = fetch_pc_q;
      endcase
   end

   assign target = {target_raw[XLEN-1:2], 2'b00};

   // Credit counts buffered entries plus reads that will still be pushed; pops this cycle are not credited.
   assign pending     = inflight_q - discard_q;
   assign credit_used = SW'(fifo_count) + SW'(pending);

   assign im.im_req  = ~rst & ~redir & ~fifo_full
                     & (inflight_q < IW'(MAX_INFLIGHT))
                     & (credit_used < SW'(DEPTH));
   assign im.im_addr = fetch_pc_q;

   assign accept = im.im_req & im.im_ready;
   assign resp   = im.im_valid;
   assign push   = resp & ~redir & (discard_q == '0);
   assign pop    = valid_f_o & ~stall_f_i & ~redir;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q + IW'(accept) - IW'(resp);
      discard_d  = discard_q;
      if (redir) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         // Everything still outstanding after this cycle belongs to the old path.
         discard_d  = inflight_d;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         if (push) begin
            resp_pc_d = resp_pc_q + STEP;
         end
         if (resp && (discard_q != '0)) begin
            discard_d = discard_q - IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({resp_pc_q, im.im_data}),
      .pop_i   (pop),
      .flush_i (redir),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign valid_f_o       = ~rst & ~fifo_empty;
   assign instruction_f_o = valid_f_o ? fifo_head[XLEN-1:0]      : '0;
   assign pc_f_o          = valid_f_o ? fifo_head[2*XLEN-1:XLEN] : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch with a randomised memory model
module tb_fetch_prefetch;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam int          MAXI     = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_d = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        pc_write = 1'b0;
   logic [31:0] pc_write_addr = '0;
   logic        stall = 1'b0;
   logic        valid_f;
   logic [31:0] instruction_f;
   logic [31:0] pc_f;

   always #5 clk = ~clk;

   fetch_prefetch_if #(.XLEN(XLEN)) im ();

   fetch_prefetch #(
      .XLEN         (XLEN),
      .DEPTH        (DEPTH),
      .MAX_INFLIGHT (MAXI),
      .RESET_PC     (RESET_PC)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .im                   (im),
      .branch_d_i           (branch_d),
      .branch_next_addr_d_i (branch_addr),
      .pc_write_m_i         (pc_write),
      .pc_next_addr_m_i     (pc_write_addr),
      .stall_f_i            (stall),
      .valid_f_o            (valid_f),
      .instruction_f_o      (instruction_f),
      .pc_f_o               (pc_f)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   // Reference: after reset or a redirect to T, the instruction stream is T, T+4, ... and
   // requests go out to the same sequence of addresses.
   logic [31:0] exp_q[$];
   logic [31:0] exp_fetch;

   task automatic expect_from(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
      exp_fetch = base;
   endtask

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t mq[$];
   req_t nr;
   int   cyc        = 0;
   int   ready_mode = 1;
   int   lat_fix    = 1;
   bit   lat_rand   = 1'b0;

   initial begin
      im.im_ready = 1'b0;
      im.im_valid = 1'b0;
      im.im_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
         end else begin
            if (im.im_valid && mq.size() > 0) void'(mq.pop_front());
            if (im.im_req && im.im_ready) begin
               nr.addr = im.im_addr;
               nr.due  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fix);
               mq.push_back(nr);
            end
         end
         @(posedge clk);
         cyc++;
         #1;
         case (ready_mode)
            0:       im.im_ready = ($urandom_range(0, 9) < 7);
            1:       im.im_ready = 1'b1;
            default: im.im_ready = 1'b0;
         endcase
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            im.im_valid = 1'b1;
            im.im_data  = mem_word(mq[0].addr);
         end else begin
            im.im_valid = 1'b0;
            im.im_data  = $urandom;
         end
      end
   end

   logic [31:0] e;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (branch_d || pc_write) begin
               check("no_req_on_redirect", 32'(im.im_req), 32'd0);
            end else if (im.im_req && im.im_ready) begin
               check("im_addr", im.im_addr, exp_fetch);
               exp_fetch = exp_fetch + 32'd4;
            end
            if (!valid_f) begin
               check("idle_pc_f", pc_f, 32'd0);
               check("idle_instruction_f", instruction_f, 32'd0);
            end else if (!stall && !branch_d && !pc_write) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL pop_underflow: got pc %h expected none", pc_f);
               end else begin
                  e = exp_q.pop_front();
                  check("pc_f", pc_f, e);
                  check("instruction_f", instruction_f, mem_word(e));
                  if (exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redirect(input logic br, input logic [31:0] bt, input logic pw, input logic [31:0] pt);
      logic [31:0] tgt;
      branch_d      = br;
      branch_addr   = bt;
      pc_write      = pw;
      pc_write_addr = pt;
      tgt           = pw ? pt : bt;
      tgt[1:0]      = 2'b00;
      expect_from(tgt);
      step(1);
      branch_d = 1'b0;
      pc_write = 1'b0;
   endtask

   initial begin
      expect_from(RESET_PC);
      @(negedge clk);
      check("reset_im_req", 32'(im.im_req), 32'd0);
      check("reset_valid_f", 32'(valid_f), 32'd0);
      step(1);
      rst = 1'b0;
      expect_from(RESET_PC);

      // Streaming with one-cycle memory latency.
      step(30);

      // Stall: FIFO fills to DEPTH and issue stops.
      stall = 1'b1;
      step(20);
      @(negedge clk);
      check("stall_im_req", 32'(im.im_req), 32'd0);
      check("stall_valid_f", 32'(valid_f), 32'd1);
      check("stall_depth", im.im_addr - pc_f, 32'(4 * DEPTH));
      step(1);
      stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         check("release_valid_f", 32'(valid_f), 32'd1);
      end
      step(1);

      // Redirect with reads outstanding.
      lat_fix = 3;
      step(10);
      redirect(1'b1, 32'h100, 1'b0, 32'h0);
      step(20);

      // Simultaneous redirects: memory stage wins.
      redirect(1'b1, 32'h200, 1'b1, 32'h300);
      step(15);

      // Unaligned target, then memory refuses for 5 cycles.
      lat_fix    = 1;
      step(5);
      ready_mode = 2;
      step(1);
      redirect(1'b1, 32'h103, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_im_req", 32'(im.im_req), 32'd1);
         check("held_im_addr", im.im_addr, 32'h100);
      end
      step(1);
      ready_mode = 1;
      step(10);

      // PC wrap.
      redirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
      step(15);

      // Reset with a loaded FIFO and reads outstanding.
      stall   = 1'b1;
      lat_fix = 3;
      step(8);
      rst   = 1'b1;
      stall = 1'b0;
      @(negedge clk);
      check("rst_im_req", 32'(im.im_req), 32'd0);
      check("rst_valid_f", 32'(valid_f), 32'd0);
      step(1);
      rst = 1'b0;
      expect_from(RESET_PC);
      @(negedge clk);
      check("post_rst_valid_f", 32'(valid_f), 32'd0);
      check("post_rst_im_addr", im.im_addr, RESET_PC);
      check("post_rst_im_req", 32'(im.im_req), 32'd1);
      step(1);
      lat_fix = 1;

      // Random traffic.
      lat_rand   = 1'b1;
      ready_mode = 0;
      for (int i = 0; i < 600; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) begin
            logic br, pw;
            br = 1'($urandom_range(0, 1));
            pw = 1'($urandom_range(0, 1));
            if (!br && !pw) br = 1'b1;
            redirect(br, $urandom, pw, $urandom);
         end else begin
            step(1);
         end
      end
      stall = 1'b0;
      step(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
